writeback_control: RTL and testbench

- Write-side control for the register file: turns the MW-latched instruction and its results into the single write port (ctrl_writeEnable, ctrl_writeReg, data_writeReg).
- Tracks one in-flight multiply/divide and retires its result, or its rstatus exception, when the multdiv unit reports ready.
- Arbitrates the one write port between MW retirement and multdiv completion using a 1-entry holding buffer.
- Sits after the MW pipeline latch; all outputs are registered.

---
 rtl/writeback_control_if.sv | 37 +++
 rtl/writeback_control.sv | 231 +++++++++++++++++++++++
 tb/tb_writeback_control.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_control_if.sv
// Register-file write-side bus: MW retirement inputs, multdiv handshake,
// and the single register-file write port.
interface writeback_control_if;
    logic        mw_valid;
    logic [31:0] mw_insn;
    logic [31:0] mw_alu;
    logic [31:0] mw_mem;
    logic [31:0] mw_pc;
    logic        mw_ovf;

    logic        md_start;
    logic [4:0]  md_rd;
    logic        md_isdiv;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;

    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        md_busy;
    logic        wb_hold;

    // Pipeline / multdiv side: presents retiring work, observes the write port
    modport master (
        output mw_valid, mw_insn, mw_alu, mw_mem, mw_pc, mw_ovf,
        output md_start, md_rd, md_isdiv, md_ready, md_result, md_exception,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_busy, wb_hold
    );

    // Writeback controller side
    modport slave (
        input  mw_valid, mw_insn, mw_alu, mw_mem, mw_pc, mw_ovf,
        input  md_start, md_rd, md_isdiv, md_ready, md_result, md_exception,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg, md_busy, wb_hold
    );
endinterface

// File: rtl/writeback_control.sv
// Writeback control: decodes the MW instruction into a register-file write,
// tracks one in-flight multiply/divide, and arbitrates the single write port
// with a one-entry holding buffer for MW writes displaced by multdiv results.
module writeback_control #(
    parameter logic [4:0] RSTATUS = 5'd30,
    parameter logic [4:0] RLINK   = 5'd31
) (
    input  logic                clock,
    input  logic                reset,
    writeback_control_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] FN_ADD   = 5'b00000;
    localparam logic [4:0] FN_SUB   = 5'b00001;
    localparam logic [4:0] FN_MUL   = 5'b00110;
    localparam logic [4:0] FN_DIV   = 5'b00111;

    state_e      state_q, state_d;
    logic [4:0]  md_rd_q, md_rd_d;
    logic        md_isdiv_q, md_isdiv_d;
    logic        buf_valid_q, buf_valid_d;
    logic [4:0]  buf_reg_q, buf_reg_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;

    logic [4:0]  opcode;
    logic [4:0]  aluop;
    logic [4:0]  rd;
    logic        mw_we;
    logic [4:0]  mw_reg;
    logic [31:0] mw_data;
    logic        mw_accept;

    logic        md_done;
    logic        md_we;
    logic [4:0]  md_reg;
    logic [31:0] md_data;

    logic        unused_insn_bits;

    assign opcode           = bus.mw_insn[31:27];
    assign rd               = bus.mw_insn[26:22];
    assign aluop            = bus.mw_insn[6:2];
    assign unused_insn_bits = ^bus.mw_insn[1:0];

    // Decode the MW instruction into at most one register-file write
    always_comb begin
        logic is_exc;
        is_exc  = 1'b0;
        mw_we   = 1'b0;
        mw_reg  = '0;
        mw_data = '0;
        unique case (opcode)
            OP_RTYPE: begin
                if (aluop != FN_MUL && aluop != FN_DIV) begin
                    mw_we = 1'b1;
                    if (bus.mw_ovf && aluop == FN_ADD) begin
                        is_exc  = 1'b1;
                        mw_reg  = RSTATUS;
                        mw_data = 32'd1;
                    end else if (bus.mw_ovf && aluop == FN_SUB) begin
                        is_exc  = 1'b1;
                        mw_reg  = RSTATUS;
                        mw_data = 32'd3;
                    end else begin
                        mw_reg  = rd;
                        mw_data = bus.mw_alu;
                    end
                end
            end
            OP_ADDI: begin
                mw_we = 1'b1;
                if (bus.mw_ovf) begin
                    is_exc  = 1'b1;
                    mw_reg  = RSTATUS;
                    mw_data = 32'd2;
                end else begin
                    mw_reg  = rd;
                    mw_data = bus.mw_alu;
                end
            end
            OP_LW: begin
                mw_we   = 1'b1;
                mw_reg  = rd;
                mw_data = bus.mw_mem;
            end
            OP_JAL: begin
                mw_we   = 1'b1;
                mw_reg  = RLINK;
                mw_data = bus.mw_pc + 32'd1;
            end
            OP_SETX: begin
                mw_we   = 1'b1;
                mw_reg  = RSTATUS;
                mw_data = {5'b0, bus.mw_insn[26:0]};
            end
            default: ;
        endcase
        if (!is_exc && mw_reg == 5'd0) begin
            mw_we = 1'b0;
        end
        if (!bus.mw_valid || !mw_we) begin
            mw_we   = 1'b0;
            mw_reg  = '0;
            mw_data = '0;
        end
    end

    // A new MW write is taken only when the buffer is empty; otherwise it is dropped
    assign mw_accept = mw_we && !buf_valid_q;

    // Multdiv completion: exception code or result to the captured destination
    always_comb begin
        md_done = (state_q == BUSY) && bus.md_ready;
        md_we   = 1'b0;
        md_reg  = '0;
        md_data = '0;
        if (md_done) begin
            if (bus.md_exception) begin
                md_we   = 1'b1;
                md_reg  = RSTATUS;
                md_data = md_isdiv_q ? 32'd5 : 32'd4;
            end else if (md_rd_q != 5'd0) begin
                md_we   = 1'b1;
                md_reg  = md_rd_q;
                md_data = bus.md_result;
            end
        end
    end

    // Multdiv tracking FSM; a start coinciding with completion recaptures
    always_comb begin
        state_d    = state_q;
        md_rd_d    = md_rd_q;
        md_isdiv_d = md_isdiv_q;
        unique case (state_q)
            IDLE: begin
                if (bus.md_start) begin
                    state_d    = BUSY;
                    md_rd_d    = bus.md_rd;
                    md_isdiv_d = bus.md_isdiv;
                end
            end
            BUSY: begin
                if (bus.md_ready) begin
                    if (bus.md_start) begin
                        md_rd_d    = bus.md_rd;
                        md_isdiv_d = bus.md_isdiv;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-port arbitration: multdiv completion, then buffer, then new MW write
    always_comb begin
        we_d        = 1'b0;
        wreg_d      = '0;
        wdata_d     = '0;
        buf_valid_d = buf_valid_q;
        buf_reg_d   = buf_reg_q;
        buf_data_d  = buf_data_q;
        if (md_done) begin
            // The completion owns the port even when its write is suppressed
            we_d    = md_we;
            wreg_d  = md_reg;
            wdata_d = md_data;
            if (mw_accept) begin
                buf_valid_d = 1'b1;
                buf_reg_d   = mw_reg;
                buf_data_d  = mw_data;
            end
        end else if (buf_valid_q) begin
            we_d        = 1'b1;
            wreg_d      = buf_reg_q;
            wdata_d     = buf_data_q;
            buf_valid_d = 1'b0;
        end else if (mw_accept) begin
            we_d    = 1'b1;
            wreg_d  = mw_reg;
            wdata_d = mw_data;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            md_rd_q     <= '0;
            md_isdiv_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_reg_q   <= '0;
            buf_data_q  <= '0;
            we_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            md_rd_q     <= md_rd_d;
            md_isdiv_q  <= md_isdiv_d;
            buf_valid_q <= buf_valid_d;
            buf_reg_q   <= buf_reg_d;
            buf_data_q  <= buf_data_d;
            we_q        <= we_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.md_busy          = (state_q == BUSY);
    assign bus.wb_hold          = buf_valid_q;

endmodule

// File: tb/tb_writeback_control.sv
// Testbench for writeback_control: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_writeback_control;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    writeback_control_if wb_if();

    writeback_control #(
        .RSTATUS(5'd30),
        .RLINK  (5'd31)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (wb_if.slave)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
    } wr_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic        m_busy  = 1'b0;
    logic [4:0]  m_rd    = '0;
    logic        m_isdiv = 1'b0;
    wr_t         m_buf[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] r_insn(input logic [4:0] rd, input logic [4:0] aluop);
        return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] i_insn(input logic [4:0] op, input logic [4:0] rd, input logic [16:0] imm);
        return {op, rd, 5'd1, imm};
    endfunction

    // Architectural meaning of a retiring instruction, as a write (or none)
    function automatic wr_t mw_effect(input logic [31:0] insn, input logic [31:0] alu,
                                      input logic [31:0] mem, input logic [31:0] pc,
                                      input logic ovf);
        wr_t w;
        logic [4:0] op, fn, rd;
        op = insn[31:27];
        rd = insn[26:22];
        fn = insn[6:2];
        w  = '0;
        if (op == 5'd0) begin
            if (fn == 5'd6 || fn == 5'd7) w = '0;
            else if (ovf && fn == 5'd0) w = {1'b1, 5'd30, 32'd1};
            else if (ovf && fn == 5'd1) w = {1'b1, 5'd30, 32'd3};
            else if (rd != 0)           w = {1'b1, rd, alu};
        end else if (op == 5'd5) begin
            if (ovf)          w = {1'b1, 5'd30, 32'd2};
            else if (rd != 0) w = {1'b1, rd, alu};
        end else if (op == 5'd8) begin
            if (rd != 0) w = {1'b1, rd, mem};
        end else if (op == 5'd3) begin
            w = {1'b1, 5'd31, pc + 32'd1};
        end else if (op == 5'd21) begin
            w = {1'b1, 5'd30, 5'd0, insn[26:0]};
        end
        return w;
    endfunction

    // One clock: predict from current inputs, advance, then compare outputs
    task automatic step();
        wr_t exp;
        wr_t cand[$];
        wr_t mw;
        logic done;
        exp = '0;
        if (reset) begin
            m_busy = 1'b0;
            m_buf.delete();
        end else begin
            done = m_busy && wb_if.md_ready;
            mw   = '0;
            if (wb_if.mw_valid && m_buf.size() == 0)
                mw = mw_effect(wb_if.mw_insn, wb_if.mw_alu, wb_if.mw_mem, wb_if.mw_pc, wb_if.mw_ovf);
            // Candidates in priority order; first one takes the port
            if (done) begin
                if (wb_if.md_exception) cand.push_back({1'b1, 5'd30, m_isdiv ? 32'd5 : 32'd4});
                else if (m_rd != 0)     cand.push_back({1'b1, m_rd, wb_if.md_result});
                else                    cand.push_back('0);
            end
            foreach (m_buf[i]) cand.push_back(m_buf[i]);
            m_buf.delete();
            if (mw.we) cand.push_back(mw);
            if (cand.size() > 0) exp = cand.pop_front();
            foreach (cand[i]) m_buf.push_back(cand[i]);
            // Multdiv occupancy
            if (!m_busy || wb_if.md_ready) begin
                if (wb_if.md_start) begin
                    m_rd    = wb_if.md_rd;
                    m_isdiv = wb_if.md_isdiv;
                end
                m_busy = wb_if.md_start;
            end
        end
        @(posedge clock);
        #1;
        check("we",   {31'd0, wb_if.ctrl_writeEnable}, {31'd0, exp.we});
        check("reg",  {27'd0, wb_if.ctrl_writeReg},    {27'd0, exp.rg});
        check("data", wb_if.data_writeReg,             exp.data);
        check("busy", {31'd0, wb_if.md_busy},          {31'd0, m_busy});
        check("hold", {31'd0, wb_if.wb_hold},          {31'd0, m_buf.size() != 0});
    endtask

    task automatic idle_inputs();
        wb_if.mw_valid     = 1'b0;
        wb_if.mw_insn      = '0;
        wb_if.mw_alu       = '0;
        wb_if.mw_mem       = '0;
        wb_if.mw_pc        = '0;
        wb_if.mw_ovf       = 1'b0;
        wb_if.md_start     = 1'b0;
        wb_if.md_rd        = '0;
        wb_if.md_isdiv     = 1'b0;
        wb_if.md_ready     = 1'b0;
        wb_if.md_result    = '0;
        wb_if.md_exception = 1'b0;
    endtask

    task automatic mw(input logic [31:0] insn, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [31:0] pc, input logic ovf);
        wb_if.mw_valid = 1'b1;
        wb_if.mw_insn  = insn;
        wb_if.mw_alu   = alu;
        wb_if.mw_mem   = mem;
        wb_if.mw_pc    = pc;
        wb_if.mw_ovf   = ovf;
    endtask

    task automatic md_issue(input logic [4:0] rd, input logic isdiv);
        wb_if.md_start = 1'b1;
        wb_if.md_rd    = rd;
        wb_if.md_isdiv = isdiv;
    endtask

    initial begin
        logic [4:0] ops[12];
        logic [4:0] fns[5];
        ops = '{5'd0, 5'd0, 5'd5, 5'd8, 5'd3, 5'd21, 5'd7, 5'd1, 5'd2, 5'd4, 5'd22, 5'd31};
        fns = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd2};

        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check("rst_we", {31'd0, wb_if.ctrl_writeEnable}, 32'd0);
        reset = 1'b0;

        // add $3 <- 7, then the same to $0
        mw(r_insn(5'd3, 5'd0), 32'd7, 32'd0, 32'd0, 1'b0);
        step();
        check("add_reg", {27'd0, wb_if.ctrl_writeReg}, 32'd3);
        check("add_data", wb_if.data_writeReg, 32'd7);
        mw(r_insn(5'd0, 5'd0), 32'd7, 32'd0, 32'd0, 1'b0);
        step();
        check("add_r0_we", {31'd0, wb_if.ctrl_writeEnable}, 32'd0);

        // Exceptions, jal, setx
        mw(i_insn(5'd5, 5'd4, 17'd5), 32'd9, 32'd0, 32'd0, 1'b1);
        step();
        check("addi_ovf", wb_if.data_writeReg, 32'd2);
        mw(r_insn(5'd6, 5'd1), 32'd9, 32'd0, 32'd0, 1'b1);
        step();
        check("sub_ovf", wb_if.data_writeReg, 32'd3);
        mw({5'd3, 27'd0}, 32'd0, 32'd0, 32'h10, 1'b0);
        step();
        check("jal_reg", {27'd0, wb_if.ctrl_writeReg}, 32'd31);
        check("jal_data", wb_if.data_writeReg, 32'h11);
        mw({5'd21, 27'h123}, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        check("setx_data", wb_if.data_writeReg, 32'h123);
        idle_inputs();
        step();

        // mul rd=5, ready 8 cycles later
        md_issue(5'd5, 1'b0);
        step();
        idle_inputs();
        for (int i = 0; i < 7; i++) step();
        wb_if.md_ready  = 1'b1;
        wb_if.md_result = 32'd42;
        step();
        check("mul_data", wb_if.data_writeReg, 32'd42);
        idle_inputs();

        // div with exception
        md_issue(5'd6, 1'b1);
        step();
        idle_inputs();
        for (int i = 0; i < 7; i++) step();
        wb_if.md_ready     = 1'b1;
        wb_if.md_exception = 1'b1;
        step();
        check("div_exc", wb_if.data_writeReg, 32'd5);
        idle_inputs();

        // Completion collides with lw retirement
        md_issue(5'd7, 1'b0);
        step();
        idle_inputs();
        step();
        wb_if.md_ready  = 1'b1;
        wb_if.md_result = 32'h55;
        mw({5'd8, 5'd9, 22'd0}, 32'd0, 32'hAB, 32'd0, 1'b0);
        step();
        check("coll_hold", {31'd0, wb_if.wb_hold}, 32'd1);
        idle_inputs();
        step();
        check("coll_buf", wb_if.data_writeReg, 32'hAB);

        // Back-to-back multdiv
        md_issue(5'd10, 1'b0);
        step();
        idle_inputs();
        step();
        wb_if.md_ready  = 1'b1;
        wb_if.md_result = 32'd100;
        md_issue(5'd11, 1'b0);
        step();
        check("b2b_busy", {31'd0, wb_if.md_busy}, 32'd1);
        idle_inputs();
        step();
        wb_if.md_ready  = 1'b1;
        wb_if.md_result = 32'd101;
        step();
        check("b2b_reg", {27'd0, wb_if.ctrl_writeReg}, 32'd11);
        idle_inputs();

        // Reset while busy with the buffer full
        md_issue(5'd12, 1'b0);
        step();
        idle_inputs();
        wb_if.md_ready = 1'b1;
        md_issue(5'd13, 1'b0);
        mw({5'd8, 5'd9, 22'd0}, 32'd0, 32'hCD, 32'd0, 1'b0);
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        check("rst_busy", {31'd0, wb_if.md_busy}, 32'd0);
        reset = 1'b0;
        wb_if.md_ready = 1'b1;
        step();
        check("rst_ready", {31'd0, wb_if.ctrl_writeEnable}, 32'd0);
        idle_inputs();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] insn;
            idle_inputs();
            reset = ($urandom_range(0, 199) == 0);
            if (m_buf.size() == 0 ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0)) begin
                insn = $urandom;
                insn[31:27] = ops[$urandom_range(0, 11)];
                insn[6:2]   = fns[$urandom_range(0, 4)];
                if ($urandom_range(0, 3) == 0) insn[26:22] = 5'd0;
                mw(insn, $urandom, $urandom, $urandom, $urandom_range(0, 2) == 0);
            end
            if (m_busy) wb_if.md_ready = ($urandom_range(0, 3) == 0);
            else        wb_if.md_ready = ($urandom_range(0, 19) == 0);
            wb_if.md_result    = $urandom;
            wb_if.md_exception = ($urandom_range(0, 4) == 0);
            if ((!m_busy || wb_if.md_ready) && $urandom_range(0, 2) == 0) begin
                md_issue(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end
            step();
        end
        reset = 1'b0;
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
